// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART frame serialiser.
// Frame: start, N data bits LSB first, optional even parity, stop.
module uart_tx_arbiter #(
  parameter int N            = 8,
  parameter int NREQ         = 2,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*N-1:0]       req_data_i,
  output logic [NREQ-1:0]         req_ack_o,
  output logic [$clog2(NREQ)-1:0] grant_id_o,
  output logic                    busy_o,
  output logic                    tx_o
);

  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q;
  logic [GW-1:0]   last_q;
  logic [GW-1:0]   gid_q;
  logic [NREQ-1:0] ack_q;
  logic [N-1:0]    shift_q;
  logic            par_q;
  logic            tx_q;
  logic            busy_q;
  logic [BW-1:0]   baud_q;
  logic [CW-1:0]   bit_q;

  logic [GW-1:0]   win_d;
  logic [GW-1:0]   idx;
  logic            found;
  logic [N-1:0]    word_d;
  logic [NREQ-1:0] oh_d;
  logic            baud_end;

  // Scan starts just after the last winner, wrapping at NREQ-1.
  always_comb begin
    win_d = last_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last_q) + k) % NREQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
  end

  always_comb begin
    word_d = '0;
    oh_d   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_d == GW'(i)) begin
        word_d  = req_data_i[i*N +: N];
        oh_d[i] = 1'b1;
      end
    end
  end

  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= GW'(NREQ - 1);
      gid_q   <= '0;
      ack_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      ack_q <= '0;
      if (state_q == S_IDLE) begin
        if (|req_valid_i) begin
          shift_q <= word_d;
          par_q   <= ^word_d;
          last_q  <= win_d;
          gid_q   <= win_d;
          ack_q   <= oh_d;
          state_q <= S_START;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
          baud_q  <= '0;
        end
      end else if (!baud_end) begin
        baud_q <= baud_q + 1'b1;
      end else begin
        baud_q <= '0;
        unique case (state_q)
          S_START: begin
            state_q <= S_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
          S_DATA: begin
            if (bit_q == CW'(N - 1)) begin
              if (PARITY_EN != 0) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
          S_PARITY: begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req_ack_o  = ack_q;
  assign grant_id_o = gid_q;
  assign busy_o     = busy_q;
  assign tx_o       = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter against a frame-level model.
// Second instance covers NREQ=3, no parity, 2 clks per bit.
module tb_uart_tx_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 2;
  localparam int CPB  = 4;
  localparam int FLEN = N + 3;
  localparam int FCYC = FLEN * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  v;
  logic [15:0] d;
  logic [1:0]  ack;
  logic [0:0]  gid;
  logic        busy;
  logic        tx;

  logic [2:0]  v3;
  logic [23:0] d3;
  logic [2:0]  ack3;
  logic [1:0]  gid3;
  logic        busy3;
  logic        tx3;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N(N), .NREQ(NREQ), .CLKS_PER_BIT(CPB), .PARITY_EN(1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(v), .req_data_i(d),
    .req_ack_o(ack), .grant_id_o(gid),
    .busy_o(busy), .tx_o(tx)
  );

  uart_tx_arbiter #(
    .N(8), .NREQ(3), .CLKS_PER_BIT(2), .PARITY_EN(0)
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid_i(v3), .req_data_i(d3),
    .req_ack_o(ack3), .grant_id_o(gid3),
    .busy_o(busy3), .tx_o(tx3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame-level reference: a frame is a list of bits, each CPB cycles.
  bit          m_act;
  int          m_cyc;
  int          m_last;
  int          m_gid;
  logic [1:0]  m_ack;
  bit          m_fr[FLEN];

  function automatic void model_reset();
    m_act  = 1'b0;
    m_cyc  = 0;
    m_last = NREQ - 1;
    m_gid  = 0;
    m_ack  = '0;
  endfunction

  function automatic void model_edge(input logic [1:0] vv,
                                     input logic [15:0] dd);
    int w;
    logic [7:0] wd;
    m_ack = '0;
    if (!m_act) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (w < 0 && vv[i]) w = i;
      end
      if (w >= 0) begin
        wd = dd[w*N +: N];
        m_fr[0] = 1'b0;
        for (int b = 0; b < N; b++) m_fr[1+b] = wd[b];
        m_fr[N+1] = ^wd;
        m_fr[N+2] = 1'b1;
        m_act  = 1'b1;
        m_cyc  = 0;
        m_last = w;
        m_gid  = w;
        m_ack[w] = 1'b1;
      end
    end else begin
      m_cyc++;
      if (m_cyc == FCYC) m_act = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    chk("tx", 32'(tx), m_act ? 32'(m_fr[m_cyc / CPB]) : 32'd1);
    chk("busy", 32'(busy), 32'(m_act));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("grant_id", 32'(gid), 32'(m_gid));
  endtask

  // keep[i]=1: requester i keeps asking after each ack.
  task automatic run(input int cycles, input logic [1:0] keep);
    for (int c = 0; c < cycles; c++) begin
      step();
      for (int i = 0; i < NREQ; i++)
        if (m_ack[i] && !keep[i]) v[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bc;
    int cnt;
    rst = 1'b1;
    v   = '0;
    d   = '0;
    v3  = '0;
    d3  = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_gid", 32'(gid), 32'd0);
    chk("rst_tx3", 32'(tx3), 32'd1);
    chk("rst_busy3", 32'(busy3), 32'd0);
    chk("rst_gid3", 32'(gid3), 32'd0);
    rst = 1'b0;

    // single frame 8'hA5 from req0
    v = 2'b01;
    d = 16'h00A5;
    bc = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (m_ack[0]) v[0] = 1'b0;
      if (busy === 1'b1) bc++;
    end
    chk("busy_cycles", 32'(bc), 32'(FCYC));

    // tie after reset: alternating grants
    do_reset();
    v = 2'b11;
    d = 16'h8001;
    run(4 * (FCYC + 1) + 4, 2'b11);
    v = 2'b00;
    run(FCYC + 2, 2'b00);

    // fairness: req1 held, req0 pulses 8'h3C mid-frame
    v = 2'b10;
    d = {8'($urandom), 8'h00};
    for (int c = 0; c < 100; c++) begin
      step();
      if (m_act && m_cyc == 10 && m_gid == 1) break;
    end
    v[0] = 1'b1;
    d[7:0] = 8'h3C;
    run(3 * (FCYC + 1), 2'b10);

    // reset in the middle of data bit 3, both pending
    v = 2'b10;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (m_act && m_cyc == 4 * CPB + 1) break;
      cnt++;
    end
    chk("reach_bit3", 32'(cnt < 200), 32'd1);
    v[0] = 1'b1;
    d[7:0] = 8'hC3;
    rst = 1'b1;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(2 * (FCYC + 1) + 4, 2'b10);
    v = 2'b00;
    run(FCYC + 2, 2'b00);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            v[i] = 1'b1;
            d[i*N +: N] = 8'($urandom);
          end else begin
            v[i] = 1'b0;
          end
        end else if (!v[i]) begin
          if ($urandom_range(3, 0) == 0) begin
            v[i] = 1'b1;
            d[i*N +: N] = 8'($urandom);
          end
        end else if ($urandom_range(31, 0) == 0) begin
          v[i] = 1'b0;
        end
      end
    end
    v = 2'b00;
    run(FCYC + 2, 2'b00);

    // NREQ=3, no parity, 2 clks/bit: 8'hFF from req2
    @(negedge clk);
    v3 = 3'b100;
    d3 = 24'hFF_0000;
    @(negedge clk);
    chk("n3_ack", 32'(ack3), 32'h4);
    chk("n3_gid", 32'(gid3), 32'd2);
    v3 = '0;
    for (int c = 0; c < 20; c++) begin
      chk("n3_tx", 32'(tx3), (c / 2 == 0) ? 32'd0 : 32'd1);
      chk("n3_busy", 32'(busy3), 32'd1);
      @(negedge clk);
    end
    chk("n3_idle_busy", 32'(busy3), 32'd0);
    chk("n3_idle_tx", 32'(tx3), 32'd1);
    chk("n3_gid_hold", 32'(gid3), 32'd2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
